// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//   Mode controller and step scheduler for the 3-LED indicator bank.
//   It builds its own millisecond timebase and steps one of four patterns
//   (run-left, run-right, bounce, blink). It also handles pause/resume and a
//   4-level speed select.
//
// Parameters
//   TICK_DIV   ms prescaler terminal count (one ms tick every TICK_DIV+1 clocks)
//   STEP_MS    base step period in ms (1..4095)
//
// Ports
//   CLK         in   system clock
//   RSTn        in   asynchronous active-low reset
//   Mode_Req    in   single-cycle pulse, advance to the next mode
//   Pause_Req   in   single-cycle pulse, toggle paused/running
//   Speed[1:0]  in   step period = STEP_MS << Speed ms
//   LED_Out[2:0]out  registered LED pattern
//   Mode_Out[1:0]out current mode (0 RUN_L, 1 RUN_R, 2 BOUNCE, 3 BLINK)
//   Paused      out  high while paused
//   Step_Pulse  out  one-cycle strobe, high when LED_Out shows a new step value
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter logic [15:0] TICK_DIV = 16'd49_999,
    parameter logic [15:0] STEP_MS  = 16'd100
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Mode_Req,
    input  logic       Pause_Req,
    input  logic [1:0] Speed,
    output logic [2:0] LED_Out,
    output logic [1:0] Mode_Out,
    output logic       Paused,
    output logic       Step_Pulse
);

    localparam logic [1:0] MODE_RUN_L  = 2'd0;
    localparam logic [1:0] MODE_RUN_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        ret_pause_reg, ret_pause_next;  // LOAD returns to PAUSE when set
    logic        paused_reg, paused_next;
    logic [1:0]  mode_reg, mode_next;
    logic [2:0]  led_reg, led_next;
    logic        dir_up_reg, dir_up_next;
    logic [15:0] ms_cnt_reg, ms_cnt_next;
    logic [15:0] step_cnt_reg, step_cnt_next;
    logic        step_pulse_reg, step_pulse_next;

    logic        ms_tick;
    logic [15:0] step_ms_scaled;
    logic [15:0] step_last;
    logic        step_due;
    logic        count_en;
    logic        load_mode;
    logic [1:0]  mode_inc;

    // Initial pattern loaded when a mode is entered.
    function automatic logic [2:0] init_pattern(input logic [1:0] mode);
        logic [2:0] r;
        case (mode)
            MODE_RUN_L:  r = 3'b001;
            MODE_RUN_R:  r = 3'b100;
            MODE_BOUNCE: r = 3'b001;
            default:     r = 3'b111;
        endcase
        return r;
    endfunction

    // One step of the active pattern, returned as {dir_up, led}.
    // Any value that does not belong to the mode falls back to its
    // initial pattern (bounce restarts heading up).
    function automatic logic [3:0] next_pattern(input logic [1:0] mode,
                                                input logic [2:0] led,
                                                input logic       dir_up);
        logic [3:0] r;
        r = {dir_up, led};
        case (mode)
            MODE_RUN_L: begin
                case (led)
                    3'b001:  r = {dir_up, 3'b010};
                    3'b010:  r = {dir_up, 3'b100};
                    3'b100:  r = {dir_up, 3'b001};
                    default: r = {1'b1, 3'b001};
                endcase
            end
            MODE_RUN_R: begin
                case (led)
                    3'b100:  r = {dir_up, 3'b010};
                    3'b010:  r = {dir_up, 3'b001};
                    3'b001:  r = {dir_up, 3'b100};
                    default: r = {1'b1, 3'b100};
                endcase
            end
            MODE_BOUNCE: begin
                // The end positions set the direction for the next move
                // away from them; the middle follows the stored direction.
                case (led)
                    3'b001:  r = {1'b1, 3'b010};
                    3'b100:  r = {1'b0, 3'b010};
                    3'b010:  r = dir_up ? {1'b1, 3'b100} : {1'b0, 3'b001};
                    default: r = {1'b1, 3'b001};
                endcase
            end
            default: begin
                case (led)
                    3'b111:  r = {dir_up, 3'b000};
                    3'b000:  r = {dir_up, 3'b111};
                    default: r = {dir_up, 3'b111};
                endcase
            end
        endcase
        return r;
    endfunction

    assign ms_tick        = (ms_cnt_reg == TICK_DIV);
    assign step_ms_scaled = STEP_MS << Speed;
    assign step_last      = step_ms_scaled - 16'd1;
    // '>=' so that lowering Speed mid-period fires on the next ms tick
    // instead of waiting for the counter to wrap.
    assign step_due       = (step_cnt_reg >= step_last);
    assign mode_inc       = mode_reg + 2'd1;

    // The timebase only advances while running. A request in RUN takes
    // priority over counting in that cycle. The LOAD cycle keeps counting
    // from zero when it returns to RUN, so a full period follows a mode change.
    assign count_en = ((state_reg == ST_RUN) && !Mode_Req && !Pause_Req) ||
                      ((state_reg == ST_LOAD) && !ret_pause_reg);

    always_comb begin
        state_next      = state_reg;
        ret_pause_next  = ret_pause_reg;
        paused_next     = paused_reg;
        mode_next       = mode_reg;
        led_next        = led_reg;
        dir_up_next     = dir_up_reg;
        ms_cnt_next     = ms_cnt_reg;
        step_cnt_next   = step_cnt_reg;
        step_pulse_next = 1'b0;
        load_mode       = 1'b0;

        if (count_en) begin
            if (ms_tick) begin
                ms_cnt_next = 16'd0;
                if (step_due) begin
                    step_cnt_next             = 16'd0;
                    {dir_up_next, led_next}   = next_pattern(mode_reg, led_reg, dir_up_reg);
                    step_pulse_next           = 1'b1;
                end else begin
                    step_cnt_next = step_cnt_reg + 16'd1;
                end
            end else begin
                ms_cnt_next = ms_cnt_reg + 16'd1;
            end
        end

        case (state_reg)
            ST_RUN: begin
                if (Mode_Req) begin
                    state_next     = ST_LOAD;
                    ret_pause_next = Pause_Req;
                    load_mode      = 1'b1;
                end else if (Pause_Req) begin
                    state_next  = ST_PAUSE;
                    paused_next = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (Mode_Req) begin
                    state_next     = ST_LOAD;
                    ret_pause_next = !Pause_Req;
                    load_mode      = 1'b1;
                end else if (Pause_Req) begin
                    state_next  = ST_RUN;
                    paused_next = 1'b0;
                end
            end
            ST_LOAD: begin
                // Requests are ignored here; just return.
                state_next = ret_pause_reg ? ST_PAUSE : ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // A mode change overrides any step that would have fired this cycle.
        if (load_mode) begin
            mode_next       = mode_inc;
            led_next        = init_pattern(mode_inc);
            dir_up_next     = 1'b1;
            ms_cnt_next     = 16'd0;
            step_cnt_next   = 16'd0;
            paused_next     = ret_pause_next;
            step_pulse_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg      <= ST_RUN;
            ret_pause_reg  <= 1'b0;
            paused_reg     <= 1'b0;
            mode_reg       <= MODE_RUN_L;
            led_reg        <= 3'b001;
            dir_up_reg     <= 1'b1;
            ms_cnt_reg     <= 16'd0;
            step_cnt_reg   <= 16'd0;
            step_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ret_pause_reg  <= ret_pause_next;
            paused_reg     <= paused_next;
            mode_reg       <= mode_next;
            led_reg        <= led_next;
            dir_up_reg     <= dir_up_next;
            ms_cnt_reg     <= ms_cnt_next;
            step_cnt_reg   <= step_cnt_next;
            step_pulse_reg <= step_pulse_next;
        end
    end

    assign LED_Out    = led_reg;
    assign Mode_Out   = mode_reg;
    assign Paused     = paused_reg;
    assign Step_Pulse = step_pulse_reg;

endmodule
